input_conditioner: RTL



---
 rtl/input_conditioner.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Debounce and event extraction between the input synchronisers and
//   comp_core. Four already-synchronised active-low inputs are debounced into
//   clean levels and single-cycle event pulses. The trip button additionally
//   gets short/long press discrimination.
//
//   Ports:
//     Clock       system clock
//     nReset      asynchronous active-low reset
//     nMode       mode button, 0 = pressed
//     nTrip       trip button, 0 = pressed
//     nFork       wheel sensor, 0 = magnet present
//     nCrank      crank sensor, 0 = magnet present
//     ModeLevel   debounced mode level, 1 = pressed
//     TripLevel   debounced trip level, 1 = pressed
//     ModePress   one-cycle pulse per debounced mode press
//     TripShort   one-cycle pulse on release of a short trip press
//     TripLong    one-cycle pulse when a trip press reaches LONG_PRESS cycles
//     ForkPulse   one-cycle pulse per debounced fork falling edge
//     CrankPulse  one-cycle pulse per debounced crank falling edge
// -----------------------------------------------------------------------------

// Single debounce channel.
//   raw      synchronised raw input
//   stable   accepted level (reset 1 = released)
//   fall     registered one-cycle flag, high in the cycle after stable 1->0
//   fall_now combinational strobe: stable goes 1->0 on this edge
//   rise_now combinational strobe: stable goes 0->1 on this edge
module input_conditioner_deb #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic fall,
  output logic fall_now,
  output logic rise_now
);

  localparam int W = $clog2(DEBOUNCE);
  localparam logic [W-1:0] C_MAX = W'(DEBOUNCE - 1);

  logic [W-1:0] cnt;
  logic         flip;

  // raw has disagreed with stable for DEBOUNCE consecutive edges
  assign flip     = (raw != stable) && (cnt == C_MAX);
  assign fall_now = flip & stable;
  assign rise_now = flip & ~stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
      fall   <= 1'b0;
    end else begin
      fall <= fall_now;
      if (raw == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// Top level.
//   Trip FSM:
//     state | meaning
//     IDLE  | trip released, waiting for a debounced press
//     HELD  | press accepted, counting hold time
//     LONG  | long press already reported, waiting for release
module input_conditioner #(
  parameter int BTN_DEBOUNCE = 164,
  parameter int SNS_DEBOUNCE = 8,
  parameter int LONG_PRESS   = 65536
) (
  input  logic Clock,
  input  logic nReset,
  input  logic nMode,
  input  logic nTrip,
  input  logic nFork,
  input  logic nCrank,
  output logic ModeLevel,
  output logic TripLevel,
  output logic ModePress,
  output logic TripShort,
  output logic TripLong,
  output logic ForkPulse,
  output logic CrankPulse
);

  localparam int HW = $clog2(LONG_PRESS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } trip_state_t;

  logic mode_s, mode_fall, mode_fall_now, mode_rise_now;
  logic trip_s, trip_fall, trip_fall_now, trip_rise_now;
  logic fork_s, fork_fall, fork_fall_now, fork_rise_now;
  logic crank_s, crank_fall, crank_fall_now, crank_rise_now;

  input_conditioner_deb #(.DEBOUNCE(BTN_DEBOUNCE)) u_mode (
    .clk(Clock), .rst_n(nReset), .raw(nMode),
    .stable(mode_s), .fall(mode_fall), .fall_now(mode_fall_now), .rise_now(mode_rise_now)
  );

  input_conditioner_deb #(.DEBOUNCE(BTN_DEBOUNCE)) u_trip (
    .clk(Clock), .rst_n(nReset), .raw(nTrip),
    .stable(trip_s), .fall(trip_fall), .fall_now(trip_fall_now), .rise_now(trip_rise_now)
  );

  input_conditioner_deb #(.DEBOUNCE(SNS_DEBOUNCE)) u_fork (
    .clk(Clock), .rst_n(nReset), .raw(nFork),
    .stable(fork_s), .fall(fork_fall), .fall_now(fork_fall_now), .rise_now(fork_rise_now)
  );

  input_conditioner_deb #(.DEBOUNCE(SNS_DEBOUNCE)) u_crank (
    .clk(Clock), .rst_n(nReset), .raw(nCrank),
    .stable(crank_s), .fall(crank_fall), .fall_now(crank_fall_now), .rise_now(crank_rise_now)
  );

  // Channel outputs this level has no use for.
  logic unused_strobes;
  assign unused_strobes = ^{mode_fall_now, mode_rise_now, trip_fall,
                            fork_s, fork_fall_now, fork_rise_now,
                            crank_s, crank_fall_now, crank_rise_now};

  assign ModeLevel  = ~mode_s;
  assign TripLevel  = ~trip_s;
  assign ModePress  = mode_fall;
  assign ForkPulse  = fork_fall;
  assign CrankPulse = crank_fall;

  trip_state_t   state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic          short_nxt, long_nxt;

  // State register; the trip pulses are registered alongside the state.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      hold      <= '0;
      TripShort <= 1'b0;
      TripLong  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold      <= hold_nxt;
      TripShort <= short_nxt;
      TripLong  <= long_nxt;
    end
  end

  // Entering HELD on the same edge the debounced level falls, and leaving on
  // the same edge it rises, aligns TripLong to LONG_PRESS cycles after
  // TripLevel rises and makes TripShort coincide with TripLevel falling.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (trip_fall_now) begin
          state_nxt = HELD;
          hold_nxt  = '0;
        end
      end
      HELD: begin
        if (hold == HOLD_MAX) begin
          state_nxt = LONG;
        end else if (trip_rise_now) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold + HW'(1);
        end
      end
      LONG: begin
        if (trip_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reaching the long threshold wins over a release on the same edge.
  always_comb begin
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    if (state == HELD) begin
      if (hold == HOLD_MAX) begin
        long_nxt = 1'b1;
      end else if (trip_rise_now) begin
        short_nxt = 1'b1;
      end
    end
  end

endmodule
